// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch program-counter stage: state encoding
// and default sizing/reset constants used by fetch_pc_ctrl and its stack.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam int DEF_PROG_CTR_WID = 10;
  localparam int DEF_STACK_DEPTH  = 4;
  localparam int DEF_RESET_VECTOR = 0;

endpackage

// File: rtl/fetch_pc_ctrl_ret_addr_stack.sv
// Return-address LIFO. The top entry is read combinationally so a return
// can redirect in the same cycle it is requested. Push and pop on a full or
// empty stack are ignored here; the caller decides what that means.
// If push and pop are requested together, push wins (the fetch controller
// never issues both).
module ret_addr_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [0:(2**IDX_W)-1];
  logic [PTR_W-1:0] sp_reg;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // sp_reg counts live entries; the next free slot is sp, the top is sp-1.
  assign wr_idx = sp_reg[IDX_W-1:0];
  assign rd_idx = wr_idx - 1'b1;
  assign full   = (sp_reg == PTR_W'(DEPTH));
  assign empty  = (sp_reg == '0);
  assign top    = mem[rd_idx];

  // Stack pointer: cleared on reset, moves by one on accepted push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + 1'b1;
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - 1'b1;
    end
  end

  // Entry storage: contents need no reset, the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch program counter and control. Drives the instruction-memory address,
// handles increment, stall, branch, call/return and halt, and marks the
// cycle after any redirect as a bubble via instr_valid.
// Build option: FETCH_CALL_STACK_EN enables the return-address stack; when
// undefined, call_en acts as a plain branch, ret_en is ignored and
// stack_err stays 0.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int                      PROG_CTR_WID = DEF_PROG_CTR_WID,
  parameter int                      STACK_DEPTH  = DEF_STACK_DEPTH,
  parameter logic [PROG_CTR_WID-1:0] RESET_VECTOR = PROG_CTR_WID'(DEF_RESET_VECTOR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [PROG_CTR_WID-1:0] branch_target,
  input  logic                    call_en,
  input  logic                    ret_en,
  input  logic                    halt_req,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic                    instr_valid,
  output logic                    halted,
  output logic                    stack_err
);

  fetch_state_e            state_reg, state_next;
  logic [PROG_CTR_WID-1:0] pc_reg, pc_next, pc_inc;
  logic                    stack_err_reg, stack_err_next;

  logic                    ret_req;
  logic                    stk_push, stk_pop, stk_full, stk_empty;
  logic [PROG_CTR_WID-1:0] stk_top;

  // Natural modulo wrap: all-ones + 1 becomes 0 with no flag.
  assign pc_inc = pc_reg + 1'b1;

`ifdef FETCH_CALL_STACK_EN
  assign ret_req = ret_en;

  ret_addr_stack #(
    .WIDTH (PROG_CTR_WID),
    .DEPTH (STACK_DEPTH)
  ) u_ret_addr_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`else
  // No stack: returns never happen and calls never see a full stack.
  logic [2:0] unused_stack;
  assign ret_req      = 1'b0;
  assign stk_full     = 1'b0;
  assign stk_empty    = 1'b1;
  assign stk_top      = '0;
  assign unused_stack = {ret_en, stk_push, stk_pop};
`endif

  // Next-state / next-PC selection in event priority order.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    stack_err_next = stack_err_reg;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    if (state_reg != ST_HALT) begin
      // FLUSH lasts one cycle unless a further redirect re-enters it.
      state_next = ST_RUN;
      if (halt_req) begin
        state_next = ST_HALT;
      end else if (ret_req) begin
        if (!stk_empty) begin
          pc_next    = stk_top;
          stk_pop    = 1'b1;
          state_next = ST_FLUSH;
        end else begin
          // Underflow: no redirect, just move on to the next word.
          pc_next        = pc_inc;
          stack_err_next = 1'b1;
        end
      end else if (call_en) begin
        // The jump is taken even when the push has to be dropped.
        stk_push       = !stk_full;
        stack_err_next = stack_err_reg | stk_full;
        pc_next        = branch_target;
        state_next     = ST_FLUSH;
      end else if (branch_taken) begin
        pc_next    = branch_target;
        state_next = ST_FLUSH;
      end else if (!stall) begin
        pc_next = pc_inc;
      end
    end
  end

  // State, PC and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_FLUSH;
      pc_reg        <= RESET_VECTOR;
      stack_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      stack_err_reg <= stack_err_next;
    end
  end

  assign prog_ctr    = pc_reg;
  assign instr_valid = (state_reg == ST_RUN);
  assign halted      = (state_reg == ST_HALT);
  assign stack_err   = stack_err_reg;

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Program-counter and fetch-control stage that sits directly upstream of the instruction memory. It drives the PROG_CTR_WID-bit fetch address into that memory. It handles sequential increment, stall, branch/jump redirect, call/return through a small return-address stack, and halt. It flags bubble cycles after redirects so the decode stage can discard stale instruction words.

Parameters:
PROG_CTR_WID, 10, fetch address width; must match the instruction memory's address width.
STACK_DEPTH, 4, number of return-address stack entries (2..16).
RESET_VECTOR, 0, value loaded into prog_ctr on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold prog_ctr; from the downstream hazard logic.
branch_taken  input  1  redirect to branch_target; resolved in execute.
branch_target  input  PROG_CTR_WID  redirect / call destination.
call_en  input  1  push return address and jump to branch_target.
ret_en  input  1  pop the return address and jump to it.
halt_req  input  1  enter HALT.
prog_ctr  output  PROG_CTR_WID  fetch address to the instruction memory.
instr_valid  output  1  the word addressed this cycle is to be consumed by decode.
halted  output  1  high in HALT.
stack_err  output  1  sticky flag: return-stack overflow or underflow.

Behaviour:
- Reset (sync, highest priority, also mid-operation):
  - prog_ctr=RESET_VECTOR, instr_valid=0, halted=0, stack_err=0.
  - Stack pointer=0 (empty); state=FLUSH.
- States and transitions:
  - RUN: instr_valid=1.
  - FLUSH: exactly one cycle; instr_valid=0; covers the instruction-memory read delay after reset or redirect. Then go to RUN. If a new redirect arrives in FLUSH, stay in FLUSH for one further cycle.
  - HALT: prog_ctr frozen, instr_valid=0, halted=1. Exited only by reset.
- Per-cycle priority, evaluated in RUN/FLUSH:
  1. halt_req: go to HALT.
  2. ret_en: prog_ctr = top of stack; pop; go to FLUSH.
  3. call_en: push prog_ctr+1; prog_ctr = branch_target; go to FLUSH.
  4. branch_taken: prog_ctr = branch_target; go to FLUSH.
  5. stall: hold prog_ctr; instr_valid unchanged.
  6. Otherwise: prog_ctr = prog_ctr+1.
- Redirects (2–4) override stall.
- Latency: a redirect presented in cycle N gives the new prog_ctr in cycle N+1, with instr_valid=0 in N+1 and instr_valid=1 from N+2 (absent further events).
- Arithmetic: prog_ctr+1 is modulo 2^PROG_CTR_WID. All-ones wraps to 0 with no flag. The pushed return address wraps the same way.
- Stack full + call_en:
  - Push dropped; stack contents unchanged.
  - Jump still taken; stack_err set.
- Stack empty + ret_en:
  - No pop; stack_err set.
  - Treated as a plain increment; state unchanged (no FLUSH).
- call_en and ret_en together: ret wins; the call is ignored entirely (no push).
- stack_err clears only on reset.

Optional Feature:
FETCH_CALL_STACK_EN.
- Defined: return-address stack, call_en/ret_en and stack_err behave as above.
- Undefined:
  - No stack storage.
  - call_en behaves exactly as branch_taken (no push).
  - ret_en is ignored.
  - stack_err is tied to 0.
  - Ports remain present.

Decomposition:
- Package fetch_pkg holds:
  - the state encoding (RUN, FLUSH, HALT);
  - the default PROG_CTR_WID and STACK_DEPTH;
  - the RESET_VECTOR constant.
- One sub-module, ret_addr_stack: a LIFO with push, pop, full, empty and top, parameterised by width and depth. It is instantiated only under FETCH_CALL_STACK_EN.

Test Plan:
- Reset, then 5 free-run cycles → prog_ctr 0,0,1,2,3,4; instr_valid 0 for the first cycle after reset, then 1.
- At prog_ctr=0x005, branch_taken=1, target=0x100 → next cycle prog_ctr=0x100 with instr_valid=0, then 0x101 with instr_valid=1. Holding stall=1 in the same cycle still redirects.
- Call to 0x200 from 0x010, run 3 cycles, ret_en → prog_ctr returns to 0x011; stack_err=0.
- Five nested calls with STACK_DEPTH=4 → the 5th call jumps but stack_err=1. Then 4 returns unwind correctly, and a 5th return increments prog_ctr without a redirect.
- Start at prog_ctr=0x3FF, no events → next prog_ctr=0x000. halt_req → prog_ctr frozen, halted=1, instr_valid=0 until reset.
